// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (core stage A, loader B)
// and the single-port BRAM.
interface dmem_port_arbiter_if #(
    parameter int unsigned MEM_AW = 16
);
    logic              a_req;
    logic              a_we;
    logic [31:0]       a_addr;
    logic [31:0]       a_wdata;
    logic [31:0]       a_rdata;
    logic              a_rvalid;
    logic              stall;

    logic              b_req;
    logic              b_we;
    logic [31:0]       b_addr;
    logic [31:0]       b_wdata;
    logic              b_gnt;
    logic [31:0]       b_rdata;
    logic              b_rvalid;

    logic              mem_en;
    logic              mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [31:0]       mem_dout;

    // Arbiter side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_rdata, a_rvalid, stall,
        input  b_req, b_we, b_addr, b_wdata,
        output b_gnt, b_rdata, b_rvalid,
        output mem_en, mem_we, mem_addr, mem_din,
        input  mem_dout
    );

    // Requester/BRAM side.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_rdata, a_rvalid, stall,
        output b_req, b_we, b_addr, b_wdata,
        input  b_gnt, b_rdata, b_rvalid,
        input  mem_en, mem_we, mem_addr, mem_din,
        output mem_dout
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares one synchronous BRAM port between the core memory stage (A) and the loader (B).
// A has priority, but B is forced through after STARVE_LIMIT consecutive A wins over it.
module dmem_port_arbiter #(
    parameter int unsigned MEM_AW       = 16,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                clk,
    input logic                rst_n,
    dmem_port_arbiter_if.slave bus
);
    localparam int unsigned     CntW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);
    localparam int unsigned     Tail   = READ_LATENCY - 1;

    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
        $error("READ_LATENCY must be 1 or 2");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    logic [CntW-1:0]         starve_cnt;
    logic                    a_busy;
    logic [READ_LATENCY-1:0] trk_vld;
    logic [READ_LATENCY-1:0] trk_own;  // 1 = loader owns the read
    logic [31:0]             a_rdata_q;
    logic [31:0]             b_rdata_q;

    logic a_elig;
    logic a_win;
    logic b_win;
    logic issue_rd;
    logic a_ret;
    logic b_ret;

    always_comb begin
        a_elig   = bus.a_req & ~a_busy;
        b_win    = bus.b_req & (~a_elig | (starve_cnt == CntMax));
        a_win    = a_elig & ~b_win;
        issue_rd = (a_win & ~bus.a_we) | (b_win & ~bus.b_we);
        a_ret    = trk_vld[Tail] & ~trk_own[Tail];
        b_ret    = trk_vld[Tail] & trk_own[Tail];
    end

    // Outputs are forced low while reset is asserted, even with requests pending.
    always_comb begin
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = '0;
        bus.mem_din  = '0;
        bus.b_gnt    = 1'b0;
        bus.stall    = 1'b0;
        if (rst_n) begin
            bus.b_gnt = b_win;
            // While an A read is outstanding the held request stays blocked; the stall drops
            // on the return cycle so the core consumes the data without a reissue.
            bus.stall = a_busy ? ~a_ret : (bus.a_req & ~(a_win & bus.a_we));
            if (b_win) begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = bus.b_we;
                bus.mem_addr = bus.b_addr[MEM_AW+1:2];
                bus.mem_din  = bus.b_wdata;
            end else if (a_win) begin
                bus.mem_en   = 1'b1;
                bus.mem_we   = bus.a_we;
                bus.mem_addr = bus.a_addr[MEM_AW+1:2];
                bus.mem_din  = bus.a_wdata;
            end
        end
    end

    always_comb begin
        bus.a_rvalid = a_ret;
        bus.b_rvalid = b_ret;
        bus.a_rdata  = a_ret ? bus.mem_dout : a_rdata_q;
        bus.b_rdata  = b_ret ? bus.mem_dout : b_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            a_busy     <= 1'b0;
            trk_vld    <= '0;
            trk_own    <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            if (b_win || !bus.b_req) begin
                starve_cnt <= '0;
            end else if (a_win && starve_cnt != CntMax) begin
                starve_cnt <= starve_cnt + CntW'(1);
            end

            if (a_win && !bus.a_we) begin
                a_busy <= 1'b1;
            end else if (a_ret) begin
                a_busy <= 1'b0;
            end

            // Writes enter the tracker as bubbles so the tail lines up with mem_dout.
            trk_vld[0] <= issue_rd;
            trk_own[0] <= b_win;
            for (int i = 1; i < READ_LATENCY; i++) begin
                trk_vld[i] <= trk_vld[i-1];
                trk_own[i] <= trk_own[i-1];
            end

            if (a_ret) begin
                a_rdata_q <= bus.mem_dout;
            end
            if (b_ret) begin
                b_rdata_q <= bus.mem_dout;
            end
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Randomised scoreboard bench: a cycle-level reference model predicts every port-access
// decision and every read return; a negedge monitor compares the DUT against those queues.
module tb_dmem_port_arbiter;
    localparam int unsigned AW = 16;
    localparam int unsigned RL = 2;
    localparam int unsigned SL = 4;
    localparam int unsigned MW = 64;

    typedef struct {
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   din;
        logic          gnt;
        logic          stall;
    } cyc_exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.MEM_AW(AW)) bus ();

    dmem_port_arbiter #(
        .MEM_AW       (AW),
        .READ_LATENCY (RL),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : 32'hA500_0000 + i * 32'h0101_0101;
    endfunction

    // BRAM environment: registered read with RL cycles of latency, junk on idle cycles.
    logic [31:0] bram [MW];
    logic [31:0] rd_pipe [RL];
    logic        bram_ready = 1'b0;
    always @(posedge clk) begin
        if (!bram_ready) begin
            for (int i = 0; i < MW; i++) bram[i] <= init_word(i);
            bram_ready <= 1'b1;
        end else if (bus.mem_en && bus.mem_we) begin
            bram[bus.mem_addr[5:0]] <= bus.mem_din;
        end
        rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? bram[bus.mem_addr[5:0]] : $urandom;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.mem_dout = rd_pipe[RL-1];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit running = 1'b0;

    logic [31:0] ref_mem [MW];
    cyc_exp_t    exp_q[$];
    rd_exp_t     a_q[$];
    rd_exp_t     b_q[$];
    int          starve;
    int          a_ret_cyc;
    bit          hold_a;
    logic        h_we;
    logic [31:0] h_addr, h_wdata;
    bit          a_seen, b_seen;
    logic [31:0] a_last, b_last;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
        end
    endfunction

    function automatic void flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d", name, cyc);
    endfunction

    // One core/loader cycle: the core keeps its request frozen while the model says stall.
    task automatic step(input logic ar, input logic aw, input logic [31:0] aa,
                        input logic [31:0] ad, input logic br, input logic bw,
                        input logic [31:0] ba, input logic [31:0] bd);
        cyc_exp_t    e;
        rd_exp_t     r;
        logic        busy, a_el, bwin, awin;
        logic [31:0] wa;
        if (hold_a) begin
            ar = 1'b1; aw = h_we; aa = h_addr; ad = h_wdata;
        end
        bus.a_req = ar; bus.a_we = aw; bus.a_addr = aa; bus.a_wdata = ad;
        bus.b_req = br; bus.b_we = bw; bus.b_addr = ba; bus.b_wdata = bd;

        busy = (a_ret_cyc >= cyc);
        a_el = ar && !busy;
        bwin = br && (!a_el || starve == SL);
        awin = a_el && !bwin;

        e.en = awin || bwin; e.we = 1'b0; e.addr = '0; e.din = '0; wa = '0;
        if (awin) begin e.we = aw; wa = aa; e.din = ad; end
        if (bwin) begin e.we = bw; wa = ba; e.din = bd; end
        if (e.en) e.addr = wa[AW+1:2];
        e.gnt   = bwin;
        e.stall = busy ? (cyc != a_ret_cyc) : (ar && !(awin && aw));
        exp_q.push_back(e);

        if (e.en && e.we) ref_mem[wa[7:2]] = e.din;
        if (e.en && !e.we) begin
            r.due  = cyc + RL;
            r.data = ref_mem[wa[7:2]];
            if (awin) a_q.push_back(r);
            else      b_q.push_back(r);
        end

        if (awin && !aw)                  a_ret_cyc = cyc + RL;
        else if (busy && cyc == a_ret_cyc) a_ret_cyc = -1;
        if (bwin || !br)                  starve = 0;
        else if (awin && starve < SL)     starve++;

        hold_a = e.stall; h_we = aw; h_addr = aa; h_wdata = ad;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        exp_q.delete(); a_q.delete(); b_q.delete();
        starve = 0; a_ret_cyc = -1; hold_a = 1'b0; a_seen = 1'b0; b_seen = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_mem_en", 32'(bus.mem_en), 0);
        chk("rst_mem_we", 32'(bus.mem_we), 0);
        chk("rst_b_gnt", 32'(bus.b_gnt), 0);
        chk("rst_a_rvalid", 32'(bus.a_rvalid), 0);
        chk("rst_b_rvalid", 32'(bus.b_rvalid), 0);
        chk("rst_stall", 32'(bus.stall), 0);
    endtask

    always @(negedge clk) begin
        cyc_exp_t e;
        rd_exp_t  r;
        if (rst_n && running) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_en", 32'(bus.mem_en), 32'(e.en));
                chk("mem_we", 32'(bus.mem_we), 32'(e.we));
                chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("mem_din", bus.mem_din, e.din);
                chk("b_gnt", 32'(bus.b_gnt), 32'(e.gnt));
                chk("stall", 32'(bus.stall), 32'(e.stall));
            end
            if (bus.a_rvalid) begin
                if (a_q.size() == 0) flag("a_rvalid_unexpected");
                else begin
                    r = a_q.pop_front();
                    chk("a_rvalid_cycle", cyc, r.due);
                    chk("a_rdata", bus.a_rdata, r.data);
                    a_seen = 1'b1; a_last = r.data;
                end
            end else begin
                if (a_q.size() > 0 && a_q[0].due <= cyc) begin
                    flag("a_rvalid_missing");
                    void'(a_q.pop_front());
                end
                if (a_seen) chk("a_rdata_hold", bus.a_rdata, a_last);
            end
            if (bus.b_rvalid) begin
                if (b_q.size() == 0) flag("b_rvalid_unexpected");
                else begin
                    r = b_q.pop_front();
                    chk("b_rvalid_cycle", cyc, r.due);
                    chk("b_rdata", bus.b_rdata, r.data);
                    b_seen = 1'b1; b_last = r.data;
                end
            end else begin
                if (b_q.size() > 0 && b_q[0].due <= cyc) begin
                    flag("b_rvalid_missing");
                    void'(b_q.pop_front());
                end
                if (b_seen) chk("b_rdata_hold", bus.b_rdata, b_last);
            end
        end
    end

    initial begin
        for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
        model_reset();
        // Requests pending during reset must not leak to any output.
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 32'h40; bus.a_wdata = 32'h1;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 32'h80; bus.b_wdata = 32'h2;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        running = 1'b1;

        step(1, 0, 32'h0000_0010, 0, 0, 0, 0, 0);          // A read of DEADBEEF
        idle(3);
        step(1, 1, 32'h0000_0020, 32'h1234_5678, 0, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 8; i++)                        // starvation: B forced on 5th
            step(1, 1, 32'h100 + 32'(i * 4), 32'(i), 1, 1, 32'h40, 32'hB0B0_0000 + 32'(i));
        idle(1);
        step(0, 0, 0, 0, 1, 0, 32'h0, 0);                  // three pipelined B reads
        step(0, 0, 0, 0, 1, 0, 32'h4, 0);
        step(0, 0, 0, 0, 1, 0, 32'h8, 0);
        idle(3);
        step(1, 0, 32'h0000_0024, 0, 1, 0, 32'hC, 0);      // A read, then B during a_busy
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 32'(i * 4), 0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, $urandom, $urandom,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom, $urandom);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        idle(RL + 3);

        // Reset pulsed the cycle after an A read issue: its data must be dropped.
        step(1, 0, 32'h0000_0030, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        bus.a_req = 1'b1; bus.b_req = 1'b1;
        #1;
        check_reset_outputs();
        model_reset();
        @(posedge clk);
        #1;
        cyc += 2;
        rst_n = 1'b1;
        idle(RL + 2);
        for (int i = 0; i < 7; i++)
            step(1, 1, 32'h200 + 32'(i * 4), 32'(i), 1, 1, 32'h44, 32'hCAFE_0000 + 32'(i));
        idle(RL + 3);

        chk("a_q_drained", 32'(a_q.size()), 0);
        chk("b_q_drained", 32'(b_q.size()), 0);
        running = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
